mem_req_arbiter: RTL and testbench

- Initiator-side front end for the shared single-port data memory of the multi-core multiplier.
- Accepts read and write requests from up to NUM_CORES multiplier cores over a valid/ready handshake and grants one request at a time.
- Drives the memory's write-enable, address and 16-bit write-data lines, captures the registered 8-bit read data, and returns it to the requesting core with a one-hot response strobe.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_req_arbiter_rr_picker.sv | 43 ++++
 rtl/mem_req_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default widths for the data-memory request arbiter.
package mem_arb_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int NUM_CORES_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Combinational request picker: round-robin from ptr_i, or lowest index first
// when MEM_ARB_FIXED_PRIO_EN is defined (ptr_i is then ignored).
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = IDX_W'(i);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
`else
        // Scan starting at the pointer, wrapping at NUM_CORES (need not be a power of two).
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_CORES);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
`endif
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Multi-core front end for the shared single-port data memory (IDLE/ACCESS/RESP).
// MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_CORES  = NUM_CORES_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CORES-1:0]              req_valid,
    input  logic [NUM_CORES-1:0]              req_we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CORES*2*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CORES-1:0]              req_ready,
    output logic [NUM_CORES-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_w_addr,
    output logic [ADDR_WIDTH-1:0]             mem_r_addr,
    output logic [2*DATA_WIDTH-1:0]           mem_w_data,
    input  logic [DATA_WIDTH-1:0]             mem_r_data
);

    localparam int IDX_W = $clog2(NUM_CORES);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        id_q, id_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_CORES-1:0]    gnt;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        pick_ptr;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`endif

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (pick_ptr),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

    assign mem_w_addr = addr_q;
    assign mem_r_addr = addr_q;
    assign mem_w_data = wdata_q;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = gnt;
                    id_d      = win_idx;
                    we_d      = req_we[win_idx];
                    addr_d    = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = req_wdata[win_idx*2*DATA_WIDTH +: 2*DATA_WIDTH];
`ifndef MEM_ARB_FIXED_PRIO_EN
                    if (int'(win_idx) == NUM_CORES - 1) rr_ptr_d = '0;
                    else                                rr_ptr_d = win_idx + 1'b1;
`endif
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                mem_we  = we_q;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (!we_q) rsp_data = mem_r_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed vectors, multi-cycle sequences and random traffic
// against a transaction-level model with its own byte-array memory image.
module tb_mem_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*2*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_data, mem_r_data;
    logic              mem_we;
    logic [AW-1:0]     mem_w_addr, mem_r_addr;
    logic [2*DW-1:0]   mem_w_data;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;
    logic [7:0] hi_addr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          core;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  exp_rsp;
    } vec_t;

    vec_t       vecs [6];
    int         gcore [5];
    logic [7:0] gaddr [5];
    logic [7:0] gdata [5];

    mem_req_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CORES  (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_r_addr (mem_r_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port memory: little-endian 16-bit write, 8-bit registered read.
    assign hi_addr = mem_w_addr + 8'd1;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (mem_we) begin
            mem[mem_w_addr] <= mem_w_data[7:0];
            mem[hi_addr]    <= mem_w_data[15:8];
        end
        mem_r_data <= mem[mem_r_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic set_req(input int core, input logic we, input logic [7:0] a, input logic [15:0] wd);
        req_valid[core]              = 1'b1;
        req_we[core]                 = we;
        req_addr[core*AW +: AW]      = a;
        req_wdata[core*2*DW +: 2*DW] = wd;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called #1 after a negedge with the request already presented; ends #1 after the
    // IDLE negedge that follows the response.
    task automatic serve(input int core, input logic we, input logic [7:0] a, input logic [15:0] wd,
                         input logic [7:0] exp_rsp, input bit drop, input logic [7:0] next_addr);
        int waited = 0;
        while (req_ready == '0 && waited < 6) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("grant_wait", waited, 0);
        chk("req_ready", req_ready, 32'(1) << core);
        @(posedge clk); #1;
        if (drop) req_valid[core] = 1'b0;
        else      req_addr[core*AW +: AW] = next_addr;
        @(negedge clk); #1;
        chk("access_mem_we", mem_we, we);
        chk("access_r_addr", mem_r_addr, a);
        chk("access_w_addr", mem_w_addr, a);
        if (we) chk("access_w_data", mem_w_data, wd);
        @(negedge clk); #1;
        chk("rsp_valid", rsp_valid, 32'(1) << core);
        chk("rsp_data", rsp_data, exp_rsp);
        @(negedge clk); #1;
        chk("rsp_one_cycle", rsp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nxt;
        bit         saw;
        int         core;

        vecs[0] = '{0, 1'b0, 8'd15,  16'h0000, 8'h01};
        vecs[1] = '{2, 1'b1, 8'd40,  16'h0903, 8'h00};
        vecs[2] = '{1, 1'b1, 8'd255, 16'hAB12, 8'h00};
        vecs[3] = '{3, 1'b0, 8'd0,   16'h0000, 8'hAB};
        vecs[4] = '{0, 1'b0, 8'd41,  16'h0000, 8'h09};
        vecs[5] = '{3, 1'b0, 8'd255, 16'h0000, 8'h12};
`ifdef MEM_ARB_FIXED_PRIO_EN
        gcore = '{0, 0, 1, 2, 3};
        gaddr = '{8'd100, 8'd110, 8'd101, 8'd102, 8'd103};
        gdata = '{8'h50, 8'h5A, 8'h51, 8'h52, 8'h53};
`else
        gcore = '{0, 1, 2, 3, 0};
        gaddr = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd110};
        gdata = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h5A};
`endif

        rst_n = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_w_addr", mem_w_addr, 0);
        chk("rst_r_addr", mem_r_addr, 0);
        chk("rst_w_data", mem_w_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single transactions, including the write that wraps to address 0.
        bd_write(8'd15, 8'h01);
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            set_req(vecs[v].core, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            #1;
            serve(vecs[v].core, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rsp, 1'b1, 8'd0);
            if (vecs[v].we) begin
                nxt = vecs[v].addr + 8'd1;
                chk("mem_low_byte", mem[vecs[v].addr], vecs[v].wdata[7:0]);
                chk("mem_high_byte", mem[nxt], vecs[v].wdata[15:8]);
            end
        end

        // All cores at once; core 0 re-requests right after its grant.
        do_reset();
        for (int i = 0; i < 4; i++) bd_write(8'(100 + i), 8'(8'h50 + i));
        bd_write(8'd110, 8'h5A);
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(100 + i), 16'h0);
        #1;
        for (int k = 0; k < 5; k++)
            serve(gcore[k], 1'b0, gaddr[k], 16'h0, gdata[k], k != 0, 8'd110);

        // Reset in the middle of a write's ACCESS cycle.
        do_reset();
        bd_write(8'd6, 8'h77);
        bd_write(8'd7, 8'h88);
        @(negedge clk);
        set_req(1, 1'b1, 8'd6, 16'h1122);
        #1;
        chk("mid_rst_ready", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        chk("mid_rst_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_after", mem_we, 0);
        chk("mid_rst_w_addr", mem_w_addr, 0);
        chk("mid_rst_w_data", mem_w_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            if (rsp_valid != '0) saw = 1'b1;
        end
        chk("mid_rst_no_rsp", saw, 0);
        chk("mid_rst_mem6", mem[6], 8'h77);
        chk("mid_rst_mem7", mem[7], 8'h88);
        @(negedge clk);
        set_req(3, 1'b0, 8'd103, 16'h0);
        set_req(0, 1'b0, 8'd100, 16'h0);
        #1;
        serve(0, 1'b0, 8'd100, 16'h0, 8'h50, 1'b1, 8'd0);
        serve(3, 1'b0, 8'd103, 16'h0, 8'h53, 1'b1, 8'd0);

        // Cores 1 and 3 held valid continuously.
        do_reset();
        @(negedge clk);
        set_req(1, 1'b0, 8'd101, 16'h0);
        set_req(3, 1'b0, 8'd103, 16'h0);
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            core = 1;
`else
            core = (k % 2 == 0) ? 1 : 3;
`endif
            serve(core, 1'b0, 8'(100 + core), 16'h0, 8'(8'h50 + core), 1'b0, 8'(100 + core));
        end

        // Random traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        begin
            int          last, free_at, acc_c, rsp_c, rsp_core, win;
            logic        acc_we;
            logic [7:0]  acc_addr, rsp_d, a;
            logic [15:0] acc_wd;
            logic [N-1:0] got, exp_ready;
            last = N - 1; free_at = 0; acc_c = -1; rsp_c = -1; rsp_core = 0;
            acc_we = 1'b0; acc_addr = '0; acc_wd = '0; rsp_d = '0; got = '0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    if (got[i]) req_valid[i] = 1'b0;
                    else if (!req_valid[i] && $urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 16'($urandom));
                end
                #1;
                exp_ready = '0;
                if (c >= free_at && req_valid != '0) begin
                    win = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
                    for (int j = N - 1; j >= 0; j--) if (req_valid[j]) win = j;
`else
                    for (int k = N; k >= 1; k--) if (req_valid[(last + k) % N]) win = (last + k) % N;
`endif
                    last      = win;
                    exp_ready = N'(1) << win;
                    free_at   = c + 3;
                    acc_c     = c + 1;
                    rsp_c     = c + 2;
                    rsp_core  = win;
                    acc_we    = req_we[win];
                    acc_addr  = req_addr[win*AW +: AW];
                    acc_wd    = req_wdata[win*2*DW +: 2*DW];
                    if (acc_we) begin
                        a = acc_addr + 8'd1;
                        ref_mem[acc_addr] = acc_wd[7:0];
                        ref_mem[a]        = acc_wd[15:8];
                        rsp_d = 8'h00;
                    end else begin
                        rsp_d = ref_mem[acc_addr];
                    end
                end
                chk("rnd_req_ready", req_ready, exp_ready);
                chk("rnd_mem_we", mem_we, (c == acc_c) && acc_we);
                if (c == acc_c) begin
                    chk("rnd_r_addr", mem_r_addr, acc_addr);
                    if (acc_we) chk("rnd_w_data", mem_w_data, acc_wd);
                end
                chk("rnd_rsp_valid", rsp_valid, (c == rsp_c) ? (32'(1) << rsp_core) : 32'(0));
                if (c == rsp_c) chk("rnd_rsp_data", rsp_data, rsp_d);
                got = req_ready;
            end
        end
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
